// File: rtl/cadence_pkg.sv
// Shared definitions for the cadence measurement path.
//   cad_state_t  : period-measurement FSM states
//   SAT_CNT_*    : saturation points of the 24-bit period counter
//   CAD_STOPPED  : scaled period reported when the rider is not pedaling
//   cap_field()  : selects the 8-bit scaled period from the raw count
package cadence_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } cad_state_t;

  // 0.3 s at 50 MHz, and a shortened value for simulation.
  localparam logic [23:0] SAT_CNT_REAL = 24'hE4E1C0;
  localparam logic [23:0] SAT_CNT_FAST = 24'h007271;
  localparam logic [7:0]  CAD_STOPPED  = 8'hE4;

  // Both windows map their SAT_CNT onto CAD_STOPPED.
  function automatic logic [7:0] cap_field(input logic [23:0] cnt, input logic fast);
    return fast ? cnt[14:7] : cnt[23:16];
  endfunction

endpackage

// File: rtl/cadence_meas_rise_det.sv
// Rising-edge detector for an input already synchronous to clk.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   sig   : input level
//   rise  : combinational, high for the single cycle where sig is 1 and its
//           registered copy is still 0
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_ff;

  always_ff @(posedge clk) begin
    if (!rst_n) sig_ff <= 1'b0;
    else        sig_ff <= sig;
  end

  assign rise = sig & ~sig_ff;

endmodule

// File: rtl/cadence_meas.sv
// Cadence period measurement: times the interval between successive rising
// edges of the debounced cadence signal with a saturating 24-bit counter.
//   clk          : system clock, 50 MHz
//   rst_n        : synchronous active-low reset
//   cadence_filt : debounced cadence input, synchronous to clk
//   cadence_per  : scaled rising-to-rising period, 8'hE4 = stopped/saturated
//   not_pedaling : high whenever cadence_per == 8'hE4
//   cadence_vld  : one-cycle pulse whenever cadence_per is rewritten
// Handshake: cadence_vld is a pure strobe with no ready; cadence_per and
// not_pedaling are valid in the same cycle cadence_vld is high and hold until
// the next strobe.
// The FSM state is the internal signal 'state' (cad_state_t).
module cadence_meas
  import cadence_pkg::*;
#(
  parameter logic FAST_SIM = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cadence_filt,
  output logic [7:0] cadence_per,
  output logic       not_pedaling,
  output logic       cadence_vld
);

  localparam logic [23:0] SAT_CNT = FAST_SIM ? SAT_CNT_FAST : SAT_CNT_REAL;

  logic       rise;
  logic [7:0] cap;
  cad_state_t state;
  logic [23:0] cnt;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cadence_filt),
    .rise  (rise)
  );

  assign cap = cap_field(cnt, FAST_SIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cadence_per  <= CAD_STOPPED;
      not_pedaling <= 1'b1;
      cadence_vld  <= 1'b0;
    end else begin
      cadence_vld <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only starts timing; there is no previous edge to
          // measure against.
          if (rise) begin
            cnt   <= 24'd1;
            state <= MEAS;
          end else begin
            cnt <= '0;
          end
        end
        MEAS: begin
          // A rise on the saturation cycle still counts as a measurement.
          if (rise) begin
            cadence_per  <= cap;
            not_pedaling <= (cap == CAD_STOPPED);
            cadence_vld  <= 1'b1;
            cnt          <= 24'd1;
          end else if (cnt == SAT_CNT) begin
            cadence_per  <= CAD_STOPPED;
            not_pedaling <= 1'b1;
            cadence_vld  <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cadence_meas.sv
// Bench for cadence_meas: one FAST_SIM=1 instance and one FAST_SIM=0 instance
// driven by directed edge sequences with hand-computed scaled periods.
module tb_cadence_meas;

  localparam int SAT_FAST = 29297; // 24'h007271

  logic       clk = 1'b0;
  logic       rst_f, cad_f, np_f, vld_f;
  logic [7:0] per_f;
  logic       rst_r, cad_r, np_r, vld_r;
  logic [7:0] per_r;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  cadence_meas #(.FAST_SIM(1'b1)) dut_fast (
    .clk          (clk),
    .rst_n        (rst_f),
    .cadence_filt (cad_f),
    .cadence_per  (per_f),
    .not_pedaling (np_f),
    .cadence_vld  (vld_f)
  );

  cadence_meas #(.FAST_SIM(1'b0)) dut_real (
    .clk          (clk),
    .rst_n        (rst_r),
    .cadence_filt (cad_r),
    .cadence_per  (per_r),
    .not_pedaling (np_r),
    .cadence_vld  (vld_r)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rise on the fast instance; outputs are sampled after the posedge
  // that ends the rise cycle.
  task automatic rise_f(input bit keep);
    cad_f = 1'b1;
    tick();
    if (!keep) cad_f = 1'b0;
  endtask

  task automatic wait_f(input int n, output int vlds);
    vlds = 0;
    repeat (n) begin
      tick();
      if (vld_f) vlds++;
    end
  endtask

  task automatic rise_r();
    cad_r = 1'b1;
    tick();
    cad_r = 1'b0;
  endtask

  task automatic wait_r(input int n, output int vlds);
    vlds = 0;
    repeat (n) begin
      tick();
      if (vld_r) vlds++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cad_f = ~cad_f;
      cad_r = ~cad_r;
      tick();
      checks++;
      if ({vld_f, per_f, np_f} !== {1'b0, 8'hE4, 1'b1}) begin
        errors++;
        $display("FAIL reset_fast[%0d]: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", i, vld_f, per_f, np_f);
      end
      checks++;
      if ({vld_r, per_r, np_r} !== {1'b0, 8'hE4, 1'b1}) begin
        errors++;
        $display("FAIL reset_real[%0d]: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", i, vld_r, per_r, np_r);
      end
    end
    cad_f = 1'b0;
    cad_r = 1'b0;
    rst_f = 1'b1;
    rst_r = 1'b1;
    tick();
    tick();
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b0, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", vld_f, per_f, np_f);
    end
  endtask

  task automatic test_first_period();
    int v;
    rise_f(1'b0);
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b0, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL first_rise: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", vld_f, per_f, np_f);
    end
    wait_f(12799, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL first_gap_vld: got %0d pulses want 0", v);
    end
    rise_f(1'b0);
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b1, 8'h64, 1'b0}) begin
      errors++;
      $display("FAIL period_12800: got vld=%0b per=%02h np=%0b want vld=1 per=64 np=0", vld_f, per_f, np_f);
    end
  endtask

  task automatic test_periods();
    int v;
    int per_tab [3] = '{25600, 128, 100};
    logic [7:0] exp_tab [3] = '{8'hC8, 8'h01, 8'h00};
    for (int i = 0; i < 3; i++) begin
      wait_f(per_tab[i] - 1, v);
      checks++;
      if (v !== 0) begin
        errors++;
        $display("FAIL period_gap_vld[%0d]: got %0d pulses want 0", i, v);
      end
      rise_f(1'b0);
      checks++;
      if ({vld_f, per_f, np_f} !== {1'b1, exp_tab[i], 1'b0}) begin
        errors++;
        $display("FAIL period_%0d: got vld=%0b per=%02h np=%0b want vld=1 per=%02h np=0", per_tab[i], vld_f, per_f, np_f, exp_tab[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int v;
    wait_f(12799, v);
    rise_f(1'b1); // held high afterwards: no further rises
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b1, 8'h64, 1'b0}) begin
      errors++;
      $display("FAIL timeout_pre: got vld=%0b per=%02h np=%0b want vld=1 per=64 np=0", vld_f, per_f, np_f);
    end
    wait_f(SAT_FAST - 1, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL timeout_early_vld: got %0d pulses want 0", v);
    end
    tick();
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b1, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL timeout_hit: got vld=%0b per=%02h np=%0b want vld=1 per=e4 np=1", vld_f, per_f, np_f);
    end
    cad_f = 1'b0; // falling edge is ignored
    wait_f(5, v);
    checks++;
    if (v !== 0 || per_f !== 8'hE4 || np_f !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: got pulses=%0d per=%02h np=%0b want pulses=0 per=e4 np=1", v, per_f, np_f);
    end
    rise_f(1'b0);
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b0, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL timeout_restart: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", vld_f, per_f, np_f);
    end
    wait_f(12799, v);
    rise_f(1'b0);
    checks++;
    if ({vld_f, per_f, np_f, v[0]} !== {1'b1, 8'h64, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_resume: got vld=%0b per=%02h np=%0b gap_pulses=%0d want vld=1 per=64 np=0 gap_pulses=0", vld_f, per_f, np_f, v);
    end
  endtask

  task automatic test_sat_collision();
    int v;
    wait_f(SAT_FAST - 1, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL collide_gap_vld: got %0d pulses want 0", v);
    end
    rise_f(1'b0); // rise on the cycle where cnt == SAT_CNT
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b1, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL collide_capture: got vld=%0b per=%02h np=%0b want vld=1 per=e4 np=1", vld_f, per_f, np_f);
    end
    wait_f(12799, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL collide_after_vld: got %0d pulses want 0", v);
    end
    rise_f(1'b0);
    checks++;
    if ({vld_f, per_f, np_f} !== {1'b1, 8'h64, 1'b0}) begin
      errors++;
      $display("FAIL collide_next: got vld=%0b per=%02h np=%0b want vld=1 per=64 np=0", vld_f, per_f, np_f);
    end
  endtask

  task automatic test_real_timing();
    int v;
    rise_r();
    checks++;
    if ({vld_r, per_r, np_r} !== {1'b0, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL real_first: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", vld_r, per_r, np_r);
    end
    // 70000 = 24'h011170: window [23:16] gives 8'h01
    wait_r(69999, v);
    rise_r();
    checks++;
    if ({vld_r, per_r, np_r, v[0]} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL real_period_70000: got vld=%0b per=%02h np=%0b gap_pulses=%0d want vld=1 per=01 np=0 gap_pulses=0", vld_r, per_r, np_r, v);
    end
    wait_r(1000, v);
    rst_r = 1'b0;
    tick();
    checks++;
    if ({vld_r, per_r, np_r} !== {1'b0, 8'hE4, 1'b1}) begin
      errors++;
      $display("FAIL real_midreset: got vld=%0b per=%02h np=%0b want vld=0 per=e4 np=1", vld_r, per_r, np_r);
    end
    cad_r = 1'b1;
    tick();
    cad_r = 1'b0;
    rst_r = 1'b1;
    wait_r(4, v);
    rise_r();
    checks++;
    if ({vld_r, per_r, np_r, v[0]} !== {1'b0, 8'hE4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL real_post_reset: got vld=%0b per=%02h np=%0b gap_pulses=%0d want vld=0 per=e4 np=1 gap_pulses=0", vld_r, per_r, np_r, v);
    end
    wait_r(100, v);
    checks++;
    if (v !== 0) begin
      errors++;
      $display("FAIL real_post_reset_gap: got %0d pulses want 0", v);
    end
  endtask

  initial begin
    rst_f = 1'b0;
    rst_r = 1'b0;
    cad_f = 1'b0;
    cad_r = 1'b0;
    test_reset();
    test_first_period();
    test_periods();
    test_timeout();
    test_sat_collision();
    test_real_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
